rom_read_sequencer: RTL and testbench

ROM_READ_SEQUENCER -- requirements
Module: rom_read_sequencer

---
 rtl/rom_seq_pkg.sv | 10 +
 rtl/rom_seq_out_reg.sv | 34 +++
 rtl/rom_read_sequencer.sv | 119 +++++++++++
 tb/tb_rom_read_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// Shared types for the ROM read sequencer: the burst-control FSM state.
package rom_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_t;

endpackage : rom_seq_pkg

// File: rtl/rom_seq_out_reg.sv
// Output register with valid/ready handshake for the ROM read sequencer.
// Holds one word. A new word may be loaded whenever the register is empty or
// its current word is being taken in the same cycle.
module rom_seq_out_reg #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             accept
);

    // The register can take a new word when empty or when being emptied this cycle.
    assign accept = !out_valid || out_ready;

    // Load a new word, or retire the held word once the consumer takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: out_data is a single visible register, so it is reset to a known zero.
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : rom_seq_out_reg

// File: rtl/rom_read_sequencer.sv
// ROM read sequencer: reads a burst of words from an asynchronous-read memory
// starting at start_addr (wrapping modulo DEPTH) and streams them out over a
// valid/ready interface. done pulses for one cycle when the burst completes.
// Optional feature: define ROM_SEQ_CHECKSUM_EN to add a `checksum` output, the
// XOR of every word transferred in the burst, valid while done=1.
module rom_read_sequencer #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [CW-1:0]    count,
    output logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
`ifdef ROM_SEQ_CHECKSUM_EN
    output logic [WIDTH-1:0] checksum,
`endif
    output logic             done
);

    import rom_seq_pkg::*;

    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    seq_state_t    state;
    logic [CW-1:0] remaining;
    logic [CW-1:0] count_sat;
    logic          accept;
    logic          load;

    // Bursts longer than the memory are clipped to one full pass.
    assign count_sat = (count > DEPTH_W) ? DEPTH_W : count;

    // A memory word is captured whenever RUN finds the output register free.
    assign load = (state == RUN) && accept;

    assign busy = (state != IDLE);

    rom_seq_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (rdata),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .accept    (accept)
    );

    // Burst control: address generation, word counting and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            raddr     <= '0;
            remaining <= '0;
            done      <= 1'b0;
        end else begin
            // NOTE: done defaults low every cycle so any set below lasts exactly one cycle.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            raddr     <= start_addr;
                            remaining <= count_sat;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        // AW-bit address wraps naturally since DEPTH is a power of two.
                        raddr     <= raddr + AW'(1);
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROM_SEQ_CHECKSUM_EN
    logic xfer;
    assign xfer = out_valid && out_ready;

    // Running XOR of transferred words, restarted by every accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule : rom_read_sequencer

// File: tb/tb_rom_read_sequencer.sv
// Self-checking bench for rom_read_sequencer (WIDTH=5, DEPTH=4).
// A queue-based burst model predicts the stream; directed bursts pin the
// model with literal values, then a randomized phase exercises handshakes,
// clamping, wrap, ignored starts and mid-burst resets.
module tb_rom_read_sequencer;

    localparam int WIDTH = 5;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [AW-1:0]    start_addr;
    logic [CW-1:0]    count;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] checksum;

    logic [WIDTH-1:0] mem [DEPTH] = '{5'd5, 5'd0, 5'd21, 5'd11};

    always #5 clk = ~clk;

    assign rdata = mem[raddr];

`ifndef ROM_SEQ_CHECKSUM_EN
    assign checksum = '0;
`endif

    rom_read_sequencer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .raddr      (raddr),
        .rdata      (rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef ROM_SEQ_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .done       (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of words the burst still has to present.
    logic [WIDTH-1:0] q_words[$];
    bit               m_idle  = 1'b1;
    logic             m_valid = 1'b0;
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_done  = 1'b0;
    logic [WIDTH-1:0] m_sum   = '0;

    task automatic model_edge();
        int  n;
        bit  xfer;
        if (rst) begin
            q_words.delete();
            m_idle  = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_done  = 1'b0;
            m_sum   = '0;
            return;
        end
        xfer   = m_valid && out_ready;
        m_done = 1'b0;
        if (xfer) m_sum = m_sum ^ m_data;
        if (m_idle) begin
            if (start) begin
                n     = (int'(count) > DEPTH) ? DEPTH : int'(count);
                m_sum = '0;
                if (n == 0) begin
                    m_done = 1'b1;
                end else begin
                    for (int i = 0; i < n; i++)
                        q_words.push_back(mem[(int'(start_addr) + i) % DEPTH]);
                    m_idle = 1'b0;
                end
            end
        end else if (q_words.size() > 0) begin
            if (!m_valid || out_ready) begin
                m_data  = q_words.pop_front();
                m_valid = 1'b1;
            end
        end else if (xfer) begin
            m_valid = 1'b0;
            m_done  = 1'b1;
            m_idle  = 1'b1;
        end
    endtask

    // Transfer bookkeeping, sampled mid-cycle when inputs are settled.
    logic             pend_x;
    logic [WIDTH-1:0] pend_d;
    always @(negedge clk) begin
        pend_x = out_valid && out_ready && !rst;
        pend_d = out_data;
    end

    int               cyc      = 0;
    int               first_v  = -1;
    int               done_cnt = 0;
    logic [WIDTH-1:0] last_sum = '0;
    logic [WIDTH-1:0] xlog[$];
    int               xcyc[$];

    // One clock: advance model, then compare every meaningful output.
    task automatic step();
        @(posedge clk);
        cyc++;
        if (pend_x) begin
            xlog.push_back(pend_d);
            xcyc.push_back(cyc);
        end
        model_edge();
        #1;
        check("out_valid", out_valid, m_valid);
        check("busy", busy, !m_idle);
        check("done", done, m_done);
        if (m_valid) check("out_data", out_data, m_data);
`ifdef ROM_SEQ_CHECKSUM_EN
        if (m_done) check("checksum", checksum, m_sum);
`endif
        if (out_valid && first_v < 0) first_v = cyc;
        if (done) begin
            done_cnt++;
            last_sum = checksum;
        end
    endtask

    task automatic clear_logs();
        xlog.delete();
        xcyc.delete();
        first_v  = -1;
        done_cnt = 0;
    endtask

    task automatic start_burst(input int sa, input int cnt);
        start      = 1'b1;
        start_addr = AW'(sa);
        count      = CW'(cnt);
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", got, 1);
    endtask

    task automatic check_log(input string name, input int n, input logic [WIDTH-1:0] e0,
                             input logic [WIDTH-1:0] e1, input logic [WIDTH-1:0] e2,
                             input logic [WIDTH-1:0] e3);
        logic [WIDTH-1:0] exp [4];
        exp = '{e0, e1, e2, e3};
        check({name, "_len"}, xlog.size(), n);
        for (int i = 0; i < n && i < xlog.size(); i++)
            check({name, "_word"}, xlog[i], exp[i]);
    endtask

    int start_cyc;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_ready  = 1'b1;

        // Reset state.
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_raddr", raddr, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        step();

        // Full burst from 0 with ready held high.
        clear_logs();
        start_cyc = cyc;
        start_burst(0, 4);
        wait_done(20);
        check_log("burst0", 4, 5'd5, 5'd0, 5'd21, 5'd11);
        check("first_valid_latency", first_v - start_cyc, 2);
        if (xcyc.size() == 4) check("burst0_back_to_back", xcyc[3] - xcyc[0], 3);
        check("burst0_done_count", done_cnt, 1);
`ifdef ROM_SEQ_CHECKSUM_EN
        check("burst0_checksum", last_sum, 27);
`endif
        step();

        // Address wrap 3 -> 0.
        clear_logs();
        start_burst(3, 3);
        wait_done(20);
        check_log("wrap", 3, 5'd11, 5'd5, 5'd0, 5'd0);
        step();

        // Backpressure: ready low for 3 cycles after the first valid.
        clear_logs();
        out_ready = 1'b0;
        start_burst(1, 2);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        check("bp_valid_seen", out_valid, 1);
        for (int i = 0; i < 2; i++) begin
            check("bp_hold_data", out_data, 0);
            step();
        end
        check("bp_hold_data", out_data, 0);
        out_ready = 1'b1;
        wait_done(20);
        check_log("bp", 2, 5'd0, 5'd21, 5'd0, 5'd0);
        step();

        // Zero-length burst.
        clear_logs();
        start_burst(2, 0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        step();
        check("zero_done_gone", done, 0);
        check("zero_no_data", xlog.size(), 0);
        check("zero_never_valid", first_v, -1);

        // Start while busy is ignored.
        clear_logs();
        start_burst(2, 2);
        start_burst(0, 4);
        wait_done(20);
        check_log("ignore", 2, 5'd21, 5'd11, 5'd0, 5'd0);
        check("ignore_done_count", done_cnt, 1);
        step();

        // Reset after the second word of a 4-word burst.
        clear_logs();
        start_burst(0, 4);
        for (int i = 0; i < 10 && xlog.size() < 2; i++) step();
        check("mid_rst_two_words", xlog.size(), 2);
        rst = 1'b1;
        step();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("mid_rst_no_done", done_cnt, 0);
        clear_logs();
        start_burst(1, 3);
        wait_done(20);
        check_log("after_rst", 3, 5'd0, 5'd21, 5'd11, 5'd0);
        step();

        // Oversized count is clipped to DEPTH.
        clear_logs();
        start_burst(2, 7);
        wait_done(20);
        check_log("clamp", 4, 5'd21, 5'd11, 5'd5, 5'd0);

        // Randomized phase against the model.
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 3) == 0);
            start_addr = AW'($urandom_range(0, DEPTH - 1));
            count      = CW'($urandom_range(0, 7));
            out_ready  = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rom_read_sequencer
